riscv_pu_fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch unit for the RISC-V pipeline.
- Owns the program counter and issues pipelined instruction reads to the memory side (valid/ready request, in-order response).
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue feeding decode.
- Handles interrupt, jump/branch and flush redirects, including discarding stale in-flight responses.
- Sits between the instruction memory/AXI-lite bridge and the decode stage.

---
 rtl/riscv_pu_fetch_queue.sv | 184 ++++++++++++++++++
 tb/tb_riscv_pu_fetch_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pu_fetch_queue.sv
// Instruction fetch unit: owns the PC, issues in-order instruction reads and buffers them in a prefetch queue.
// Define RISCV_FETCH_PERF_EN to add the o_redirect_cnt / o_starve_cnt performance counters.
module riscv_pu_fetch_queue #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_jump_branch,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_interr,
  input  logic [ADDR_WIDTH-1:0]  i_interr_addr,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_req_addr,
  input  logic                   i_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_rsp_data,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic                   o_flush
`ifdef RISCV_FETCH_PERF_EN
  ,
  output logic [31:0]            o_redirect_cnt,
  output logic [31:0]            o_starve_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [CW-1:0]          live_q, live_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic                   flush_q;
  logic [PW-1:0]          q_rd_q, q_wr_q, pp_rd_q, pp_wr_q;
  logic [INSTR_WIDTH-1:0] q_instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0]  pp_mem      [DEPTH];

  logic                   redirect, req_fire, req_hold, rsp_drop, push, pop, issue_ok;
  logic [ADDR_WIDTH-1:0]  target;

  assign redirect = i_interr | i_jump_branch | i_flush;
  assign target   = i_interr ? i_interr_addr : i_pc;
  assign req_fire = req_valid_q & i_req_ready;
  assign req_hold = req_valid_q & ~i_req_ready;
  assign rsp_drop = i_rsp_valid & (redirect | (discard_q != '0));
  assign push     = i_rsp_valid & ~rsp_drop;
  assign pop      = (count_q != '0) & ~i_stall & enable & ~redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    live_d      = live_q;
    discard_d   = discard_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (redirect) begin
      // Everything already in flight, including a request accepted this cycle, becomes stale.
      live_d    = '0;
      discard_d = discard_q + live_q + CW'(req_fire) - CW'(i_rsp_valid);
      count_d   = '0;
      if (req_hold) begin
        pend_d      = 1'b1;
        pend_addr_d = target;
      end else begin
        pend_d     = 1'b0;
        fetch_pc_d = target;
      end
    end else begin
      if (req_fire) begin
        if (pend_q) begin
          discard_d  = discard_q + CW'(1);
          fetch_pc_d = pend_addr_q;
          pend_d     = 1'b0;
        end else begin
          live_d     = live_q + CW'(1);
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      if (i_rsp_valid) begin
        if (discard_q != '0) discard_d = discard_d - CW'(1);
        else                 live_d    = live_d - CW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Credit check on next-state counters lets requests issue back to back.
  assign issue_ok    = enable & ~pend_d
                     & (({1'b0, count_d} + {1'b0, live_d}) < DEPTH_X)
                     & (({1'b0, live_d} + {1'b0, discard_d}) < DEPTH_X);
  assign req_valid_d = req_hold | issue_ok;
  assign req_addr_d  = req_hold ? req_addr_q : fetch_pc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      live_q      <= '0;
      discard_q   <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      flush_q     <= 1'b0;
      q_rd_q      <= '0;
      q_wr_q      <= '0;
      pp_rd_q     <= '0;
      pp_wr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_mem[i] <= '0;
        q_pc_mem[i]    <= '0;
        pp_mem[i]      <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      live_q      <= live_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      flush_q     <= redirect;
      if (req_fire) begin
        pp_mem[pp_wr_q] <= req_addr_q;
        pp_wr_q         <= pp_wr_q + PW'(1);
      end
      // Every response, kept or dropped, consumes its address from the pc pipe.
      if (i_rsp_valid) pp_rd_q <= pp_rd_q + PW'(1);
      if (push) begin
        q_instr_mem[q_wr_q] <= i_rsp_data;
        q_pc_mem[q_wr_q]    <= pp_mem[pp_rd_q];
      end
      if (redirect) begin
        q_rd_q <= '0;
        q_wr_q <= '0;
      end else begin
        if (push) q_wr_q <= q_wr_q + PW'(1);
        if (pop)  q_rd_q <= q_rd_q + PW'(1);
      end
    end
  end

  assign o_req_valid   = req_valid_q;
  assign o_req_addr    = req_addr_q;
  assign o_instr_valid = (count_q != '0);
  assign o_instr       = q_instr_mem[q_rd_q];
  assign o_pc          = q_pc_mem[q_rd_q];
  assign o_flush       = flush_q;

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] redirect_cnt_q, starve_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      if (redirect && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (enable && (count_q == '0) && !redirect && (starve_cnt_q != '1))
        starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign o_redirect_cnt = redirect_cnt_q;
  assign o_starve_cnt   = starve_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_pu_fetch_queue.sv
// Directed self-checking bench for riscv_pu_fetch_queue with an in-order, fixed-latency memory model.
module tb_riscv_pu_fetch_queue;

  logic        clk, reset, enable, i_stall, i_flush, i_jump_branch, i_interr;
  logic [63:0] i_pc, i_interr_addr, o_req_addr, o_pc;
  logic        o_req_valid, i_req_ready, i_rsp_valid, o_instr_valid, o_flush;
  logic [31:0] i_rsp_data, o_instr;
`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] o_redirect_cnt, o_starve_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;
  int flush_cnt = 0;
  logic [63:0] got_pc[$];
  logic [31:0] got_in[$];
  logic [63:0] req_log[$];
  logic [63:0] mq_addr[$];
  int          mq_due[$];

  riscv_pu_fetch_queue dut (
    .clk(clk), .reset(reset), .enable(enable), .i_stall(i_stall), .i_flush(i_flush),
    .i_jump_branch(i_jump_branch), .i_pc(i_pc), .i_interr(i_interr), .i_interr_addr(i_interr_addr),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .o_instr_valid(o_instr_valid),
    .o_instr(o_instr), .o_pc(o_pc), .o_flush(o_flush)
`ifdef RISCV_FETCH_PERF_EN
    , .o_redirect_cnt(o_redirect_cnt), .o_starve_cnt(o_starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // Memory model: accepted requests answered in order, lat cycles later; forgets everything on reset.
  initial begin
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (o_req_valid && i_req_ready) begin
        mq_addr.push_back(o_req_addr);
        mq_due.push_back(cyc + lat);
        req_log.push_back(o_req_addr);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        i_rsp_valid = 1'b1;
        i_rsp_data  = mdata(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        i_rsp_valid = 1'b0;
      end
    end
  end

  // Decode-side monitor: records every instruction actually consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && o_instr_valid && !i_stall && enable && !(i_interr || i_jump_branch || i_flush)) begin
        got_pc.push_back(o_pc);
        got_in.push_back(o_instr);
      end
      if (!reset && o_flush) flush_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    got_pc.delete();
    got_in.delete();
    req_log.delete();
    flush_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; i_req_ready = 1'b1;
    tick(2);
    n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", o_req_valid); end
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", o_instr_valid); end
    n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", o_flush); end
    n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", o_instr); end
    n_checks++; if (o_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    lat = 1; i_stall = 1'b0; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    tick(20);
    n_checks++;
    if (got_pc.size() < 6 || req_log.size() < 6) begin
      n_fail++; $display("FAIL stream_count: got %0d delivered %0d requests expected >=6", got_pc.size(), req_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++; if (req_log[k] !== 64'(4*k)) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", k, req_log[k], 64'(4*k)); end
        n_checks++; if (got_pc[k] !== 64'(4*k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, got_pc[k], 64'(4*k)); end
        n_checks++; if (got_in[k] !== mdata(64'(4*k))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, got_in[k], mdata(64'(4*k))); end
      end
    end
    n_checks++; if (flush_cnt !== 0) begin n_fail++; $display("FAIL stream_no_flush: got %0d flush cycles expected 0", flush_cnt); end
    $display("test_stream done: %0d instructions delivered", got_pc.size());
  endtask

  task automatic test_stall_credit();
    lat = 1; i_stall = 1'b1; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    tick(10);
    n_checks++; if (req_log.size() !== 4) begin n_fail++; $display("FAIL stall_req_count: got %0d expected 4", req_log.size()); end
    n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b expected 0", o_req_valid); end
    n_checks++; if (got_pc.size() !== 0) begin n_fail++; $display("FAIL stall_no_pop: got %0d expected 0", got_pc.size()); end
    n_checks++; if (o_instr_valid !== 1'b1 || o_pc !== 64'h0) begin n_fail++; $display("FAIL stall_head: got valid=%b pc=%h expected valid=1 pc=0", o_instr_valid, o_pc); end
    i_stall = 1'b0;
    tick(12);
    n_checks++;
    if (got_pc.size() < 5 || req_log.size() < 5) begin
      n_fail++; $display("FAIL stall_release_count: got %0d delivered %0d requests expected >=5", got_pc.size(), req_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++; if (got_pc[k] !== 64'(4*k) || got_in[k] !== mdata(64'(4*k))) begin
          n_fail++; $display("FAIL stall_release[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", k, got_pc[k], got_in[k], 64'(4*k), mdata(64'(4*k)));
        end
      end
      n_checks++; if (req_log[4] !== 64'h10) begin n_fail++; $display("FAIL stall_resume_addr: got %h expected 10", req_log[4]); end
    end
    $display("test_stall_credit done");
  endtask

  task automatic test_jump_discard();
    lat = 4; i_stall = 1'b0; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    tick(3); enable = 1'b0;
    tick(1); enable = 1'b1; i_jump_branch = 1'b1; i_pc = 64'h100;
    tick(1); i_jump_branch = 1'b0;
    n_checks++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush_pulse: got %b expected 1", o_flush); end
    n_checks++; if (req_log.size() !== 3) begin n_fail++; $display("FAIL jump_inflight: got %0d expected 3", req_log.size()); end
    n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h100) begin n_fail++; $display("FAIL jump_next_req: got valid=%b addr=%h expected 1/100", o_req_valid, o_req_addr); end
    tick(1);
    n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL jump_flush_single: got %b expected 0", o_flush); end
    tick(2);
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_stale_dropped: got %b expected 0", o_instr_valid); end
    tick(6);
    n_checks++;
    if (got_pc.size() < 1) begin
      n_fail++; $display("FAIL jump_delivered: got 0 instructions expected >=1");
    end else begin
      n_checks++; if (got_pc[0] !== 64'h100 || got_in[0] !== mdata(64'h100)) begin
        n_fail++; $display("FAIL jump_first: got pc=%h instr=%h expected pc=100 instr=%h", got_pc[0], got_in[0], mdata(64'h100));
      end
    end
    $display("test_jump_discard done");
  endtask

  task automatic test_interrupt_held();
    bit found = 0;
    lat = 1; i_stall = 1'b0; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    for (int t = 0; t < 40 && !found; t++) begin
      if (o_req_valid && o_req_addr == 64'h20) found = 1;
      else tick(1);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL interr_find_req: request at 20 not seen within 40 cycles");
    end else begin
      i_req_ready = 1'b0;
      tick(1); i_interr = 1'b1; i_interr_addr = 64'h800; i_pc = 64'h300;
      tick(1); i_interr = 1'b0;
      got_pc.delete(); got_in.delete(); req_log.delete();
      n_checks++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL interr_flush: got %b expected 1", o_flush); end
      n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h20) begin n_fail++; $display("FAIL interr_hold1: got valid=%b addr=%h expected 1/20", o_req_valid, o_req_addr); end
      tick(1);
      n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 64'h20) begin n_fail++; $display("FAIL interr_hold2: got valid=%b addr=%h expected 1/20", o_req_valid, o_req_addr); end
      i_req_ready = 1'b1;
      tick(8);
      n_checks++;
      if (req_log.size() < 2 || got_pc.size() < 1) begin
        n_fail++; $display("FAIL interr_progress: got %0d requests %0d delivered expected >=2/>=1", req_log.size(), got_pc.size());
      end else begin
        n_checks++; if (req_log[0] !== 64'h20) begin n_fail++; $display("FAIL interr_held_fire: got %h expected 20", req_log[0]); end
        n_checks++; if (req_log[1] !== 64'h800) begin n_fail++; $display("FAIL interr_vector_req: got %h expected 800", req_log[1]); end
        n_checks++; if (got_pc[0] !== 64'h800 || got_in[0] !== mdata(64'h800)) begin
          n_fail++; $display("FAIL interr_first: got pc=%h instr=%h expected pc=800 instr=%h", got_pc[0], got_in[0], mdata(64'h800));
        end
      end
    end
    $display("test_interrupt_held done");
  endtask

  task automatic test_priority();
    lat = 1; i_stall = 1'b0; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    tick(2); i_interr = 1'b1; i_interr_addr = 64'h800; i_jump_branch = 1'b1; i_pc = 64'h100;
    tick(1); i_interr = 1'b0; i_jump_branch = 1'b0;
    got_pc.delete(); got_in.delete(); req_log.delete();
    n_checks++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL prio_flush: got %b expected 1", o_flush); end
    n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL prio_rsp_dropped: got %b expected 0", o_instr_valid); end
    tick(6);
    n_checks++;
    if (req_log.size() < 1 || got_pc.size() < 1) begin
      n_fail++; $display("FAIL prio_progress: got %0d requests %0d delivered expected >=1", req_log.size(), got_pc.size());
    end else begin
      n_checks++; if (req_log[0] !== 64'h800) begin n_fail++; $display("FAIL prio_target: got %h expected 800", req_log[0]); end
      n_checks++; if (got_pc[0] !== 64'h800 || got_in[0] !== mdata(64'h800)) begin
        n_fail++; $display("FAIL prio_first: got pc=%h instr=%h expected pc=800 instr=%h", got_pc[0], got_in[0], mdata(64'h800));
      end
    end
    $display("test_priority done");
  endtask

  task automatic test_reset_midstream();
    lat = 2; i_stall = 1'b0; enable = 1'b1; i_req_ready = 1'b1;
    apply_reset();
    tick(6); reset = 1'b1;
    tick(1);
    n_checks++; if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0 || o_flush !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valids: got req=%b instr=%b flush=%b expected 0/0/0", o_req_valid, o_instr_valid, o_flush);
    end
    n_checks++; if (o_instr !== 32'h0 || o_pc !== 64'h0) begin n_fail++; $display("FAIL midreset_head: got instr=%h pc=%h expected 0/0", o_instr, o_pc); end
    reset = 1'b0;
    got_pc.delete(); got_in.delete(); req_log.delete();
    tick(10);
    n_checks++;
    if (req_log.size() < 2 || got_pc.size() < 2) begin
      n_fail++; $display("FAIL midreset_progress: got %0d requests %0d delivered expected >=2", req_log.size(), got_pc.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (req_log[k] !== 64'(4*k)) begin n_fail++; $display("FAIL midreset_req[%0d]: got %h expected %h", k, req_log[k], 64'(4*k)); end
        n_checks++; if (got_pc[k] !== 64'(4*k) || got_in[k] !== mdata(64'(4*k))) begin
          n_fail++; $display("FAIL midreset_instr[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", k, got_pc[k], got_in[k], 64'(4*k), mdata(64'(4*k)));
        end
      end
    end
    $display("test_reset_midstream done");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_jump_branch = 1'b0;
    i_interr = 1'b0; i_pc = '0; i_interr_addr = '0; i_req_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_credit();
    test_jump_discard();
    test_interrupt_held();
    test_priority();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
